umi_pkt_serializer: RTL and testbench

//  Downstream stage of the UMI RX sim source. Consumes 256-bit UMI packets over a valid/ready handshake.
//  Re-emits each packet as NBEATS = 256/DW narrower beats with a last flag.

---
 rtl/umi_pkt_serializer.sv | 76 +++++++
 tb/tb_umi_pkt_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/umi_pkt_serializer.sv
// umi_pkt_serializer: splits each 256-bit UMI packet into 256/DW beats, LSB first, with a last flag.
// in_ready depends combinationally on out_ready so a new packet can load on the final beat with no bubble.
module umi_pkt_serializer #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [255:0]  in_packet,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int NBEATS = 256 / DW;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64 || DW == 128 || DW == 256)) begin : g_bad_dw
        $error("umi_pkt_serializer: illegal DW=%0d", DW);
    end

    state_t         r_state;
    state_t         w_next_state;
    logic [255:0]   r_pkt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_next_cnt;
    logic           w_accept;
    logic           w_beat;

    assign out_valid = (r_state == SEND);
    assign out_data  = r_pkt[32'(r_cnt) * DW +: DW];
    assign out_last  = (r_cnt == CW'(NBEATS - 1));
    assign in_ready  = (r_state == IDLE) | (out_valid & out_ready & out_last);
    assign w_accept  = in_valid & in_ready;
    assign w_beat    = out_valid & out_ready;

    // Next state and beat counter; a load on the final beat overrides the return to IDLE
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (w_beat && !out_last) begin
            w_next_cnt = r_cnt + CW'(1);
        end
        if (w_beat && out_last) begin
            w_next_state = IDLE;
            w_next_cnt   = '0;
        end
        if (w_accept) begin
            w_next_state = SEND;
            w_next_cnt   = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Packet holding register, loaded only on accept so stalls keep it frozen
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pkt <= '0;
        end else if (w_accept) begin
            r_pkt <= in_packet;
        end
    end
endmodule

// File: tb/tb_umi_pkt_serializer.sv
// tb_umi_pkt_serializer: directed checks of the serializer at DW = 64, 32, 256 and 8.
module tb_umi_pkt_serializer;
    logic clk;
    logic nreset;
    int   n_tests;
    int   n_fail;

    logic [255:0] a_pkt;  logic a_iv, a_ir, a_ol, a_ov, a_or;  logic [63:0]  a_od;
    logic [255:0] b_pkt;  logic b_iv, b_ir, b_ol, b_ov, b_or;  logic [31:0]  b_od;
    logic [255:0] c_pkt;  logic c_iv, c_ir, c_ol, c_ov, c_or;  logic [255:0] c_od;
    logic [255:0] d_pkt;  logic d_iv, d_ir, d_ol, d_ov, d_or;  logic [7:0]   d_od;

    umi_pkt_serializer #(.DW(64)) u_dw64 (
        .clk(clk), .nreset(nreset), .in_packet(a_pkt), .in_valid(a_iv), .in_ready(a_ir),
        .out_data(a_od), .out_last(a_ol), .out_valid(a_ov), .out_ready(a_or));
    umi_pkt_serializer #(.DW(32)) u_dw32 (
        .clk(clk), .nreset(nreset), .in_packet(b_pkt), .in_valid(b_iv), .in_ready(b_ir),
        .out_data(b_od), .out_last(b_ol), .out_valid(b_ov), .out_ready(b_or));
    umi_pkt_serializer #(.DW(256)) u_dw256 (
        .clk(clk), .nreset(nreset), .in_packet(c_pkt), .in_valid(c_iv), .in_ready(c_ir),
        .out_data(c_od), .out_last(c_ol), .out_valid(c_ov), .out_ready(c_or));
    umi_pkt_serializer #(.DW(8)) u_dw8 (
        .clk(clk), .nreset(nreset), .in_packet(d_pkt), .in_valid(d_iv), .in_ready(d_ir),
        .out_data(d_od), .out_last(d_ol), .out_valid(d_ov), .out_ready(d_or));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane(input int p, input int k);
        return 64'h0101010101010101 * 64'(16 * (p + 1) + k);
    endfunction

    function automatic logic [255:0] pkt64(input int p);
        return {lane(p, 3), lane(p, 2), lane(p, 1), lane(p, 0)};
    endfunction

    initial begin
        logic [255:0] p1, r;
        logic [255:0] q[$];
        int p, b, cyc;
        bit exp_ir;
        n_tests = 0;
        n_fail  = 0;
        nreset = 1'b0;
        {a_pkt, a_iv, a_or} = '0;
        {b_pkt, b_iv, b_or} = '0;
        {c_pkt, c_iv, c_or} = '0;
        {d_pkt, d_iv, d_or} = '0;
        repeat (2) @(negedge clk);
        check("rst_ov64", 256'(a_ov), 0);
        check("rst_od64", 256'(a_od), 0);
        check("rst_ol64", 256'(a_ol), 0);
        check("rst_ir64", 256'(a_ir), 1);
        check("rst_ol256", 256'(c_ol), 1);
        check("rst_ov256", 256'(c_ov), 0);
        nreset = 1'b1;

        // single packet, lanes 1111..4444, out_ready held high
        p1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        @(negedge clk);
        a_pkt = p1; a_iv = 1'b1; a_or = 1'b1;
        #1 check("t1_ir", 256'(a_ir), 1);
        check("t1_ov_pre", 256'(a_ov), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1 check("t1_ov", 256'(a_ov), 1);
            check("t1_od", 256'(a_od), 256'(64'h1111111111111111 * 64'(k + 1)));
            check("t1_ol", 256'(a_ol), 256'(k == 3));
        end
        @(negedge clk);
        #1 check("t1_ov_post", 256'(a_ov), 0);

        // three packets back to back, no idle cycles
        a_pkt = pkt64(0); a_iv = 1'b1;
        #1 check("t2_ir0", 256'(a_ir), 1);
        p = 1;
        for (b = 0; b < 12; b++) begin
            @(negedge clk);
            a_iv  = (p < 3);
            a_pkt = (p < 3) ? pkt64(p) : '0;
            #1 check("t2_ov", 256'(a_ov), 1);
            check("t2_od", 256'(a_od), 256'(lane(b / 4, b % 4)));
            check("t2_ol", 256'(a_ol), 256'(b % 4 == 3));
            check("t2_ir", 256'(a_ir), 256'(b % 4 == 3));
            if (b % 4 == 3) p++;
        end
        @(negedge clk);
        a_iv = 1'b0;
        #1 check("t2_ov_post", 256'(a_ov), 0);

        // stalls: out_ready pattern 1,0,0 repeating
        a_pkt = pkt64(5); a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 40) begin
            a_or = (cyc % 3 == 0);
            #1 check("t3_ov", 256'(a_ov), 1);
            check("t3_od", 256'(a_od), 256'(lane(5, b)));
            check("t3_ol", 256'(a_ol), 256'(b == 3));
            if (a_or) b++;
            cyc++;
            @(negedge clk);
        end
        check("t3_beats", 256'(b), 4);
        #1 check("t3_ov_post", 256'(a_ov), 0);
        a_or = 1'b0;

        // DW=8: byte k = k
        for (int k = 0; k < 32; k++) d_pkt[8*k +: 8] = 8'(k);
        d_iv = 1'b1; d_or = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            d_iv = 1'b0;
            #1 check("t6_ov", 256'(d_ov), 1);
            check("t6_od", 256'(d_od), 256'(k));
            check("t6_ol", 256'(d_ol), 256'(k == 31));
        end
        @(negedge clk);
        d_or = 1'b0;
        #1 check("t6_ov_post", 256'(d_ov), 0);

        // DW=256: random traffic against a one-deep scoreboard
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) c_pkt[32*j +: 32] = $urandom;
            c_iv = 1'($urandom);
            c_or = 1'($urandom);
            #1 check("t5_ol", 256'(c_ol), 1);
            check("t5_ov", 256'(c_ov), 256'(q.size() != 0));
            exp_ir = (q.size() == 0) || c_or;
            check("t5_ir", 256'(c_ir), 256'(exp_ir));
            if (q.size() != 0 && c_or) begin
                check("t5_od", c_od, q[0]);
                void'(q.pop_front());
            end
            if (c_iv && exp_ir) q.push_back(c_pkt);
        end
        @(negedge clk);
        c_iv = 1'b0; c_or = 1'b1;
        if (q.size() != 0) begin
            #1 check("t5_drain", c_od, q[0]);
        end
        @(negedge clk);
        c_or = 1'b0;

        // DW=32: reset after three beats, then a fresh packet
        for (int k = 0; k < 8; k++) b_pkt[32*k +: 32] = 32'hC0DE0000 + 32'(k);
        b_iv = 1'b1; b_or = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_iv = 1'b0;
            #1 check("t4_od", 256'(b_od), 256'(32'hC0DE0000 + 32'(k)));
        end
        @(negedge clk);
        #1 check("t4_beat3", 256'(b_od), 256'(32'hC0DE0003));
        nreset = 1'b0;
        #1 check("t4_ov_rst", 256'(b_ov), 0);
        check("t4_od_rst", 256'(b_od), 0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        #1 check("t4_ir_rel", 256'(b_ir), 1);
        check("t4_ov_rel", 256'(b_ov), 0);
        for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'hBEEF0000 + 32'(k);
        b_pkt = r; b_iv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_iv = 1'b0;
            #1 check("t4_ov2", 256'(b_ov), 1);
            check("t4_od2", 256'(b_od), 256'(32'hBEEF0000 + 32'(k)));
            check("t4_ol2", 256'(b_ol), 256'(k == 7));
        end
        @(negedge clk);
        #1 check("t4_ov_end", 256'(b_ov), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
